// File: rtl/instr_queue_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package   : codes
// Purpose   : Instruction field types and bit positions used by the instruction
//             queue and its field decoder.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
package codes;

  typedef logic [5:0]  opcode_t;
  typedef logic [5:0]  funct_t;
  typedef logic [4:0]  regaddr_t;
  typedef logic [4:0]  size_t;
  typedef logic [15:0] imm_t;
  typedef logic [25:0] target_t;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHIFT_HI  = 10;
  localparam int SHIFT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  localparam opcode_t OP_LW  = 6'h23;
  localparam funct_t  FN_ADD = 6'h20;

  typedef struct packed {
    opcode_t  opcode;
    funct_t   funct;
    size_t    shift;
    regaddr_t rs;
    regaddr_t rt;
    regaddr_t rd;
    imm_t     immediate;
    target_t  target;
  } ir_fields_t;

  function automatic ir_fields_t split_word(input logic [31:0] w);
    ir_fields_t f;
    f.opcode    = w[OPCODE_HI:OPCODE_LO];
    f.funct     = w[FUNCT_HI:FUNCT_LO];
    f.shift     = w[SHIFT_HI:SHIFT_LO];
    f.rs        = w[RS_HI:RS_LO];
    f.rt        = w[RT_HI:RT_LO];
    f.rd        = w[RD_HI:RD_LO];
    f.immediate = w[IMM_HI:IMM_LO];
    f.target    = w[TARGET_HI:TARGET_LO];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_queue_ir_decode.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module    : ir_decode
// Purpose   : Purely combinational split of a 32-bit instruction word into fields.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
module ir_decode
  import codes::*;
(
  input  logic [31:0] word_i,
  output opcode_t     opcode_o,
  output funct_t      funct_o,
  output size_t       shift_o,
  output regaddr_t    rs_o,
  output regaddr_t    rt_o,
  output regaddr_t    rd_o,
  output imm_t        immediate_o,
  output target_t     target_o
);

  ir_fields_t w_fields;

  assign w_fields    = split_word(word_i);
  assign opcode_o    = w_fields.opcode;
  assign funct_o     = w_fields.funct;
  assign shift_o     = w_fields.shift;
  assign rs_o        = w_fields.rs;
  assign rt_o        = w_fields.rt;
  assign rd_o        = w_fields.rd;
  assign immediate_o = w_fields.immediate;
  assign target_o    = w_fields.target;

endmodule
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module    : instr_queue
// Purpose   : Circular instruction FIFO between fetch and decode with decoded
//             head-word fields. Define INSTR_QUEUE_BYPASS_EN to let a push into
//             an empty queue appear at the outputs in the same cycle.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
module instr_queue
  import codes::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     reset_n_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [IW-1:0]            instr_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output opcode_t                  opcode_o,
  output funct_t                   funct_o,
  output size_t                    shift_o,
  output regaddr_t                 rs_o,
  output regaddr_t                 rt_o,
  output regaddr_t                 rd_o,
  output imm_t                     immediate_o,
  output target_t                  target_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  logic          w_full;
  logic          w_stored_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_store;
  logic          w_advance_rd;
  logic [IW-1:0] w_head;
  logic [31:0]   w_dec_word;

  assign w_full         = (r_count == CW'(DEPTH));
  assign w_stored_valid = (r_count != '0);
  assign push_ready_o   = !w_full || pop_i;
  assign w_push         = push_valid_i && push_ready_o && !flush_i;
  assign w_pop          = pop_i && valid_o;
  assign w_advance_rd   = pop_i && w_stored_valid;

`ifdef INSTR_QUEUE_BYPASS_EN
  logic w_bypass;
  // An empty queue presents the incoming word directly; if decode takes it now it never lands in storage.
  assign w_bypass = !w_stored_valid && push_valid_i && !flush_i;
  assign valid_o  = w_stored_valid || w_bypass;
  assign w_head   = w_stored_valid ? r_mem[r_rd_ptr] : instr_i;
  assign w_store  = w_push && !(w_bypass && pop_i);
`else
  assign valid_o  = w_stored_valid;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_store  = w_push;
`endif

  // Zeroing the word ahead of the decoder forces every field to 0 when nothing is presented.
  assign w_dec_word = valid_o ? w_head[31:0] : 32'd0;
  assign count_o    = r_count;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_advance_rd) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= instr_i;
    end
  end

  ir_decode u_ir_decode (
    .word_i      (w_dec_word),
    .opcode_o    (opcode_o),
    .funct_o     (funct_o),
    .shift_o     (shift_o),
    .rs_o        (rs_o),
    .rt_o        (rt_o),
    .rd_o        (rd_o),
    .immediate_o (immediate_o),
    .target_o    (target_o)
  );

endmodule
`default_nettype wire

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction entries (power of two, >=2).
REQ-002 SHALL have parameter IW, default 32, instruction width in bits (>=32; fields from bits [31:0]).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 push_valid_i  input  1  fetch offers instr_i this cycle.
REQ-006 push_ready_o  output  1  queue accepts a push this cycle.
REQ-007 instr_i  input  IW  fetched instruction word.
REQ-008 pop_i  input  1  decode consumes head entry this cycle.
REQ-009 flush_i  input  1  discard all entries (branch/jump redirect).
REQ-010 valid_o  output  1  head entry present; field outputs meaningful.
REQ-011 count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 opcode_o/funct_o/shift_o/rs_o/rt_o/rd_o/immediate_o/target_o  output  6/6/5/5/5/5/16/26  head-word fields: [31:26],[5:0],[10:6],[25:21],[20:16],[15:11],[15:0],[25:0].

Function
REQ-013 SHALL implement a circular FIFO: write pointer, read pointer, occupancy counter, each log2(DEPTH) wrapping modulo DEPTH (counter excepted).
REQ-014 push_ready_o SHALL be 1 when count_o < DEPTH or (count_o == DEPTH and pop_i == 1).
REQ-015 Push occurs when push_valid_i && push_ready_o; word stored at write pointer, pointer increments.
REQ-016 Pop occurs when pop_i && valid_o; read pointer increments; pop_i with valid_o==0 SHALL be ignored.
REQ-017 Simultaneous push and pop SHALL leave count_o unchanged, including when full or when count_o==1.
REQ-018 Field outputs SHALL be combinational slices of the head word; when valid_o==0 they SHALL be driven to 0.
REQ-019 Head word SHALL stay stable while valid_o==1 and no pop occurs (replaces single-word hold register).
REQ-020 flush_i SHALL have priority: next cycle count_o==0, pointers 0, valid_o==0; a push in the flush cycle SHALL be dropped.
REQ-021 Push-to-valid latency SHALL be 1 cycle (empty queue, no bypass).
REQ-022 Pointer wrap at DEPTH-1 -> 0 SHALL be seamless; no entry lost or duplicated.

Reset
REQ-023 On reset_n_i==0, immediately: pointers 0, count_o 0, valid_o 0, field outputs 0, push_ready_o 1 after release.
REQ-024 Reset mid-stream SHALL discard all entries; storage array need not be cleared.
REQ-025 Reset release SHALL be synchronised externally; first push accepted on the first edge with reset_n_i==1.

Configuration
REQ-026 Macro INSTR_QUEUE_BYPASS_EN SHALL enable empty-queue bypass.
REQ-027 With macro: when count_o==0 and push_valid_i==1 and flush_i==0, valid_o==1 and fields SHALL reflect instr_i in the same cycle; if pop_i also 1, word is consumed and not stored.
REQ-028 Without macro: no combinational path instr_i -> field outputs/valid_o; REQ-021 latency applies.

Structure
REQ-029 opcode_t, funct_t, regaddr_t, size_t and field bit-position constants SHALL live in package codes; no local redefinition.
REQ-030 Field slicing SHALL be a sub-module ir_decode (combinational, word in, fields out), instantiated once on the head/bypass word.
REQ-031 Storage SHALL be a flat register array; no memory macro.

Verification
REQ-032 Reset then push 0x8C8A0004 (lw) with pop_i=0 -> next cycle valid_o=1, opcode_o=0x23, rs_o=4, rt_o=10, immediate_o=0x0004, count_o=1.
REQ-033 DEPTH=4: push 5 words, no pops -> push_ready_o=0 after 4th, 5th not stored; pop all -> order 1..4, then valid_o=0.
REQ-034 Full queue, push and pop same cycle -> count_o stays 4, push_ready_o=1, new word emerges after 4 further pops; repeat 10 times to exercise wrap.
REQ-035 count_o=3, assert flush_i with push_valid_i=1 -> next cycle count_o=0, valid_o=0; pushed word never appears.
REQ-036 Assert reset_n_i=0 mid-stream off a clock edge -> valid_o and count_o drop to 0 without waiting for clk.
REQ-037 With INSTR_QUEUE_BYPASS_EN, empty queue, push 0x00851020 (add) with pop_i=1 -> same cycle valid_o=1, funct_o=0x20, rd_o=2; next cycle count_o=0.
